// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM port status, arbiter state and grant owner.
package memory_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic [1:0] {IDLE, D_GNT, I_GNT} arb_state_t;

    typedef enum logic {OWN_D, OWN_I} arb_owner_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the memory arbiter.
interface memory_arbiter_if
    import memory_arbiter_pkg::*;
#(
    parameter int CPUS = 2
);
    logic [CPUS-1:0]  iREN;
    word_t [CPUS-1:0] iaddr;
    logic [CPUS-1:0]  iwait;
    word_t [CPUS-1:0] iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dlock;
    logic      dwait;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    logic      arb_err;

    // slave: the arbiter itself; master: the caches plus the RAM model driving it
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, dlock, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, dlock, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
    );

endinterface

// File: rtl/memory_arbiter_rr_select.sv
// Combinational round-robin finder: first set request at or after the pointer, wrapping.
module rr_select #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = ptr_i;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data path with locked bursts versus round-robin instruction
// fetch, with a starvation counter that forces a pending fetch through.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int CPUS         = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int BURST_MAX    = 2
) (
    input  logic           CLK,
    input  logic           RST,
    memory_arbiter_if.slave bus
);

    localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
    localparam int BU_W  = $clog2(BURST_MAX + 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [ST_W-1:0]  starve_q, starve_d;
    logic [BU_W-1:0]  burst_q, burst_d;

    logic             any_i;
    logic [IDX_W-1:0] pick_idx;
    logic             d_req;
    logic             owner_en;
    logic             granted;
    logic             complete;
    logic             ram_err;
    logic             starve_inc;
    logic [BU_W-1:0]  burst_inc;

    rr_select #(.N(CPUS), .IDX_W(IDX_W)) u_rr (
        .req_i   (bus.iREN),
        .ptr_i   (rr_q),
        .found_o (any_i),
        .idx_o   (pick_idx)
    );

    assign d_req     = bus.dREN | bus.dWEN;
    assign granted   = (state_q != IDLE);
    assign ram_err   = granted && (bus.ramstate == ERROR);
    assign complete  = owner_en && (bus.ramstate == ACCESS);
    assign burst_inc = burst_q + BU_W'(1);
    assign bus.arb_err = ram_err;

    always_comb begin
        unique case (state_q)
            D_GNT:   owner_en = d_req;
            I_GNT:   owner_en = bus.iREN[idx_q];
            default: owner_en = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            rr_q     <= '0;
            starve_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_q     <= rr_d;
            starve_q <= starve_d;
            burst_q  <= burst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rr_d       = rr_q;
        starve_d   = starve_q;
        burst_d    = burst_q;
        starve_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_i && starve_q == ST_W'(STARVE_LIMIT)) begin
                    state_d = I_GNT;
                    idx_d   = pick_idx;
                end else if (d_req) begin
                    state_d    = D_GNT;
                    starve_inc = any_i;
                end else if (any_i) begin
                    state_d = I_GNT;
                    idx_d   = pick_idx;
                end
            end
            D_GNT: begin
                starve_inc = any_i;
                if (!owner_en || ram_err) begin
                    state_d = IDLE;
                    burst_d = '0;
                end else if (complete) begin
                    if (bus.dlock && burst_inc < BU_W'(BURST_MAX)) begin
                        burst_d = burst_inc;
                    end else begin
                        state_d = IDLE;
                        burst_d = '0;
                    end
                end
            end
            I_GNT: begin
                if (!owner_en || ram_err) begin
                    state_d = IDLE;
                end else if (complete) begin
                    state_d  = IDLE;
                    starve_d = '0;
                    rr_d     = (idx_q == IDX_W'(CPUS - 1)) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (starve_inc && starve_q != ST_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + ST_W'(1);
        end
    end

    // RAM port and requester returns follow the current owner combinationally.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = '1;
        bus.iload    = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        unique case (state_q)
            D_GNT: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dload    = bus.ramload;
                bus.dwait    = ~complete;
            end
            I_GNT: begin
                bus.ramREN       = bus.iREN[idx_q];
                bus.ramaddr      = bus.iaddr[idx_q];
                bus.iload[idx_q] = bus.ramload;
                bus.iwait[idx_q] = ~complete;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST && state_q == D_GNT) begin
            assert (!(bus.dREN && bus.dWEN))
                else $warning("dREN and dWEN both high during data grant; write takes priority");
        end
    end

endmodule
